// File: rtl/change_dispenser_if.sv
// change_dispenser_if: groups every non-clock, non-reset signal of
// change_dispenser into one bundle.
//   master modport: the side that drives give/product/change and the
//                   actuator acks, clear and refill (vending_mach side or bench).
//   slave modport : the dispenser itself.
//   Request side : give, product[1:0], change[4:0], clear, refill
//   Actuator side: product_release, product_sel[1:0], coin10_eject,
//                  coin5_eject, eject_ack
//   Status       : busy, done, error, overrun, shortfall[4:0],
//                  coin10_stock, coin5_stock
//                  paid_total[9:0] only when DISPENSE_COUNT_EN is defined.
interface change_dispenser_if #(
  parameter int STOCK_W = 5
);
  logic               give;
  logic [1:0]         product;
  logic [4:0]         change;
  logic               eject_ack;
  logic               clear;
  logic               refill;
  logic               product_release;
  logic [1:0]         product_sel;
  logic               coin10_eject;
  logic               coin5_eject;
  logic               busy;
  logic               done;
  logic               error;
  logic               overrun;
  logic [4:0]         shortfall;
  logic [STOCK_W-1:0] coin10_stock;
  logic [STOCK_W-1:0] coin5_stock;
`ifdef DISPENSE_COUNT_EN
  logic [9:0]         paid_total;
`endif

  modport master (
    output give, product, change, eject_ack, clear, refill,
    input  product_release, product_sel, coin10_eject, coin5_eject,
    input  busy, done, error, overrun, shortfall, coin10_stock, coin5_stock
`ifdef DISPENSE_COUNT_EN
    , input paid_total
`endif
  );

  modport slave (
    input  give, product, change, eject_ack, clear, refill,
    output product_release, product_sel, coin10_eject, coin5_eject,
    output busy, done, error, overrun, shortfall, coin10_stock, coin5_stock
`ifdef DISPENSE_COUNT_EN
    , output paid_total
`endif
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: downstream of vending_mach. On a give strobe it releases
// the selected product, then pays the change greedily as 10 Rs and 5 Rs
// coins, one actuator handshake at a time, tracking coin-tube stock.
// Unpayable residue or a missing ack parks the block in FAULT until clear.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : change_dispenser_if.slave (request, actuator and status signals)
// Optional build macro DISPENSE_COUNT_EN adds bus.paid_total, a saturating
// count of rupees paid out (unaffected by refill and clear).
module change_dispenser #(
  parameter int COIN10_INIT = 8,
  parameter int COIN5_INIT  = 8,
  parameter int STOCK_W     = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [STOCK_W-1:0] C10_INIT  = STOCK_W'(COIN10_INIT);
  localparam logic [STOCK_W-1:0] C5_INIT   = STOCK_W'(COIN5_INIT);
  localparam logic [STOCK_W-1:0] ONE       = STOCK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RELEASE, S_DECIDE, S_EJ10, S_EJ5, S_DONE, S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         remaining_q, remaining_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         sel_q, sel_d;
  logic [STOCK_W-1:0] c10_q, c10_d;
  logic [STOCK_W-1:0] c5_q, c5_d;
  logic [4:0]         short_q, short_d;
  logic               overrun_q, overrun_d;
`ifdef DISPENSE_COUNT_EN
  logic [9:0]         paid_q, paid_d;
  logic [10:0]        paid_sum;
`endif

  // State register.
  // NOTE: reset is sampled on the clock edge (synchronous); all state uses
  // non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wait_q      <= '0;
      sel_q       <= 2'b00;
      c10_q       <= C10_INIT;
      c5_q        <= C5_INIT;
      short_q     <= '0;
      overrun_q   <= 1'b0;
`ifdef DISPENSE_COUNT_EN
      paid_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      c10_q       <= c10_d;
      c5_q        <= c5_d;
      short_q     <= short_d;
      overrun_q   <= overrun_d;
`ifdef DISPENSE_COUNT_EN
      paid_q      <= paid_d;
`endif
    end
  end

  // Next-state and datapath.
  // NOTE: every _d gets a hold default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    sel_d       = sel_q;
    c10_d       = c10_q;
    c5_d        = c5_q;
    short_d     = short_q;
    overrun_d   = overrun_q;

    // clear outranks a simultaneous give, so a dropped give never re-arms it.
    if (bus.clear)                         overrun_d = 1'b0;
    else if (bus.give && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (bus.refill) begin
          c10_d = C10_INIT;
          c5_d  = C5_INIT;
        end
        if (bus.give) begin
          sel_d       = bus.product;
          remaining_d = bus.change;
          state_d     = (bus.product != 2'b00) ? S_RELEASE : S_DECIDE;
        end
      end
      S_RELEASE, S_EJ10, S_EJ5: begin
        if (bus.eject_ack) begin
          state_d = S_DECIDE;
          if (state_q == S_EJ10) begin
            remaining_d = remaining_q - 5'd10;
            c10_d       = c10_q - ONE;
          end else if (state_q == S_EJ5) begin
            remaining_d = remaining_q - 5'd5;
            c5_d        = c5_q - ONE;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          short_d = remaining_q;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECIDE: begin
        // Entering any wait state from here starts its ack timer at zero.
        wait_d = '0;
        if (remaining_q == 5'd0)                       state_d = S_DONE;
        else if (remaining_q >= 5'd10 && c10_q != '0)  state_d = S_EJ10;
        else if (remaining_q >= 5'd5 && c5_q != '0)    state_d = S_EJ5;
        else begin
          state_d = S_FAULT;
          short_d = remaining_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: begin
        if (bus.clear) begin
          state_d = S_IDLE;
          short_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DISPENSE_COUNT_EN
  // Saturating payout total: overflow bit of the 11-bit sum pins it at 1023.
  always_comb begin
    paid_sum = {1'b0, paid_q};
    if (bus.eject_ack && state_q == S_EJ10)     paid_sum = paid_sum + 11'd10;
    else if (bus.eject_ack && state_q == S_EJ5) paid_sum = paid_sum + 11'd5;
    paid_d = paid_sum[10] ? 10'h3FF : paid_sum[9:0];
  end
`endif

  // Outputs: requests are decoded from state, so they fall the cycle after ack.
  always_comb begin
    bus.product_release = (state_q == S_RELEASE);
    bus.coin10_eject    = (state_q == S_EJ10);
    bus.coin5_eject     = (state_q == S_EJ5);
    bus.busy            = (state_q != S_IDLE);
    bus.done            = (state_q == S_DONE);
    bus.error           = (state_q == S_FAULT);
    bus.product_sel     = sel_q;
    bus.overrun         = overrun_q;
    bus.shortfall       = short_q;
    bus.coin10_stock    = c10_q;
    bus.coin5_stock     = c5_q;
`ifdef DISPENSE_COUNT_EN
    bus.paid_total      = paid_q;
`endif
  end
endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int INIT10 = 8;
  localparam int INIT5  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_if #(.STOCK_W(5)) bus ();
  change_dispenser #(
    .COIN10_INIT(INIT10), .COIN5_INIT(INIT5), .STOCK_W(5), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  // Reference model state: coins left in each tube and rupees paid so far.
  int m10, m5, m_paid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] reqs();
    return {bus.product_release, bus.coin10_eject, bus.coin5_eject};
  endfunction

  // which: 0 any request, 1 done, 2 error. Bounded wait on negedges.
  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((which == 0 && reqs() != 3'b000) || (which == 1 && bus.done) ||
          (which == 2 && bus.error)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_stock(input string tag);
    check({tag, "_coin10_stock"}, bus.coin10_stock, m10);
    check({tag, "_coin5_stock"}, bus.coin5_stock, m5);
`ifdef DISPENSE_COUNT_EN
    check({tag, "_paid_total"}, bus.paid_total, m_paid);
`endif
  endtask

  task automatic do_refill();
    bus.refill = 1'b1;
    @(negedge clk);
    bus.refill = 1'b0;
    m10 = INIT10;
    m5  = INIT5;
    check_stock("refill");
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("clear_error", bus.error, 0);
    check("clear_busy", bus.busy, 0);
    check("clear_shortfall", bus.shortfall, 0);
    check("clear_overrun", bus.overrun, 0);
  endtask

  // One full transaction. The expected coin mix is worked out up front from
  // the tube contents: as many tens as fit, then as many fives as fit.
  task automatic run_txn(input logic [1:0] prod, input int chg, input int dly,
                         input bit inject, output bit faulted);
    int rem, n10, n5;
    int ev[$];
    bit ok, injected;
    rem = chg;
    n10 = rem / 10; if (n10 > m10) n10 = m10; rem -= 10 * n10;
    n5  = rem / 5;  if (n5 > m5)   n5  = m5;  rem -= 5 * n5;
    if (prod != 2'b00) ev.push_back(0);
    repeat (n10) ev.push_back(1);
    repeat (n5) ev.push_back(2);

    bus.product = prod;
    bus.change  = 5'(chg);
    bus.give    = 1'b1;
    @(negedge clk);
    bus.give = 1'b0;
    check("busy_after_give", bus.busy, 1);
    injected = 1'b0;

    foreach (ev[k]) begin
      wait_for(0, ok);
      check("req_seen", ok, 1);
      if (!ok) begin
        faulted = 1'b1;
        return;
      end
      check("req_kind", reqs(), (ev[k] == 0) ? 3'b100 : (ev[k] == 1) ? 3'b010 : 3'b001);
      if (ev[k] == 0) check("product_sel", bus.product_sel, prod);
      if (inject && ev[k] == 1 && !injected) begin
        bus.give    = 1'b1;
        bus.product = 2'b11;
        bus.change  = 5'd31;
        injected    = 1'b1;
      end
      repeat (dly) begin
        @(negedge clk);
        bus.give = 1'b0;
        check("req_held", reqs() != 3'b000, 1);
      end
      bus.eject_ack = 1'b1;
      @(negedge clk);
      bus.eject_ack = 1'b0;
      bus.give      = 1'b0;
      check("req_drop_after_ack", reqs(), 0);
      if (ev[k] == 1) begin m10--; m_paid += 10; end
      if (ev[k] == 2) begin m5--;  m_paid += 5;  end
      if (m_paid > 1023) m_paid = 1023;
    end

    if (rem == 0) begin
      wait_for(1, ok);
      check("done_pulse", bus.done, 1);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("idle_after_done", bus.busy, 0);
      faulted = 1'b0;
    end else begin
      wait_for(2, ok);
      check("error", bus.error, 1);
      check("shortfall", bus.shortfall, rem);
      check("no_req_in_fault", reqs(), 0);
      faulted = 1'b1;
    end
    check_stock("txn");
    if (inject) check("overrun", bus.overrun, 1);
  endtask

  initial begin
    bit f, ok;
    int cnt;
    reset         = 1'b1;
    bus.give      = 1'b0;
    bus.product   = 2'b00;
    bus.change    = 5'd0;
    bus.eject_ack = 1'b0;
    bus.clear     = 1'b0;
    bus.refill    = 1'b0;
    m10 = INIT10; m5 = INIT5; m_paid = 0;
    repeat (2) @(negedge clk);
    check("rst_reqs", reqs(), 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_shortfall", bus.shortfall, 0);
    check("rst_product_sel", bus.product_sel, 0);
    check_stock("rst");
    reset = 1'b0;
    @(negedge clk);

    // Product plus 15 Rs: release, one ten, one five.
    run_txn(2'b11, 15, 2, 1'b0, f);
    check("s1_stock10", bus.coin10_stock, 7);
    check("s1_stock5", bus.coin5_stock, 7);

    // Refund only: two tens, no release.
    do_refill();
    run_txn(2'b00, 20, 1, 1'b0, f);
    check("s2_stock10", bus.coin10_stock, 6);

    // Drain tens to one, then 25 Rs falls back to fives.
    do_refill();
    run_txn(2'b00, 30, 0, 1'b0, f);
    run_txn(2'b00, 30, 0, 1'b0, f);
    run_txn(2'b00, 10, 0, 1'b0, f);
    run_txn(2'b01, 25, 1, 1'b0, f);
    check("s3_stock10", bus.coin10_stock, 0);
    check("s3_stock5", bus.coin5_stock, 5);
    check("s3_no_error", bus.error, 0);

    // Odd change: one five then fault with 2 Rs unpaid.
    run_txn(2'b10, 7, 1, 1'b0, f);
    check("s4_faulted", f, 1);
    // give and clear together in FAULT: clear wins, give dropped.
    bus.product = 2'b11; bus.change = 5'd10;
    bus.give = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.give = 1'b0; bus.clear = 1'b0;
    check("s4_clear_error", bus.error, 0);
    check("s4_give_dropped", bus.busy, 0);
    check("s4_clear_shortfall", bus.shortfall, 0);
    check("s4_clear_overrun", bus.overrun, 0);
    run_txn(2'b01, 0, 1, 1'b0, f);

    // No ack at all: RELEASE times out after 15 cycles.
    bus.product = 2'b11; bus.change = 5'd10; bus.give = 1'b1;
    @(negedge clk);
    bus.give = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && bus.product_release; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("s5_release_cycles", cnt, 15);
    check("s5_error", bus.error, 1);
    check("s5_shortfall", bus.shortfall, 10);
    check("s5_release_low", bus.product_release, 0);
    do_clear();
    check_stock("s5");

    // give during EJ10 sets overrun without disturbing the payout.
    do_refill();
    run_txn(2'b00, 10, 2, 1'b1, f);
    // Reset while a five is pending abandons it and restores full tubes.
    bus.product = 2'b00; bus.change = 5'd5; bus.give = 1'b1;
    @(negedge clk);
    bus.give = 1'b0;
    wait_for(0, ok);
    check("s6_coin5_req", bus.coin5_eject, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m10 = INIT10; m5 = INIT5; m_paid = 0;
    check("s6_rst_reqs", reqs(), 0);
    check("s6_rst_busy", bus.busy, 0);
    check("s6_rst_overrun", bus.overrun, 0);
    check_stock("s6_rst");

    // Stray ack in IDLE is ignored.
    bus.eject_ack = 1'b1;
    @(negedge clk);
    bus.eject_ack = 1'b0;
    check("stray_ack_busy", bus.busy, 0);
    check_stock("stray_ack");

    // Random transactions against the model; tubes drain and get refilled.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) do_refill();
      run_txn(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), 1'b0, f);
      if (f) do_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of vending_mach. Consumes its give/product/change result and drives the physical actuators.
- Releases the selected product, then pays out change as 10 Rs and 5 Rs coins, one actuator handshake at a time.
- Tracks coin-tube stock and flags any shortfall.

Parameters:
COIN10_INIT, 8, coin10 stock after reset/refill
COIN5_INIT, 8, coin5 stock after reset/refill
STOCK_W, 5, stock counter width
ACK_TIMEOUT, 15, cycles to wait for eject_ack before fault

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
give  input  1  one-cycle strobe from vending_mach; samples product/change
product  input  2  00 none (cancel/refund), 01 Lemonwater, 10 Sodabottle, 11 Waterbottle
change  input  5  rupees to return, 0..31
eject_ack  input  1  actuator completion pulse
clear  input  1  clears FAULT state and overrun
refill  input  1  reloads both stocks to INIT values
product_release  output  1  product actuator request
product_sel  output  2  latched product code, valid while product_release=1
coin10_eject  output  1  10 Rs coin actuator request
coin5_eject  output  1  5 Rs coin actuator request
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
error  output  1  high while in FAULT
overrun  output  1  sticky: give arrived while busy
shortfall  output  5  unpaid rupees, valid in FAULT
coin10_stock  output  STOCK_W  remaining 10 Rs coins
coin5_stock  output  STOCK_W  remaining 5 Rs coins

Behaviour:
- Decided: one clock clk; reset is synchronous and active-high, named reset.
- Reset values:
  - All request outputs, done, error, overrun, busy = 0; shortfall = 0; product_sel = 00.
  - coin10_stock = COIN10_INIT, coin5_stock = COIN5_INIT; state = IDLE.
  - Reset mid-operation abandons the transaction; outputs take reset values on the next edge.
- States: IDLE, RELEASE, DECIDE, EJ10, EJ5, DONE, FAULT.
- IDLE:
  - On give: latch product into product_sel and change into remaining.
  - Next state is RELEASE if product != 00, else DECIDE.
  - refill in IDLE reloads both stocks; refill in any other state is ignored.
- RELEASE: product_release=1 until the cycle eject_ack=1; then DECIDE.
- DECIDE (one cycle, no request asserted), priority order:
  - remaining==0 -> DONE.
  - remaining>=10 and coin10_stock>0 -> EJ10.
  - remaining>=5 and coin5_stock>0 -> EJ5.
  - Otherwise -> FAULT, shortfall=remaining.
  - Greedy by value; coin10 exhaustion falls back to coin5.
- EJ10/EJ5:
  - Request held high until eject_ack.
  - On ack: remaining -= 10 or 5; matching stock -= 1; then DECIDE.
  - Requests deassert in the cycle after ack; at most one request is high in any cycle.
- Timeout:
  - A wait counter resets on entry to RELEASE/EJ10/EJ5 and increments each cycle without ack.
  - Reaching ACK_TIMEOUT -> FAULT, shortfall=remaining; a product not yet released is not paid back.
- DONE: done=1 for exactly one cycle; then IDLE.
- FAULT:
  - error=1; shortfall held; no actuator requests.
  - clear -> IDLE, error=0, shortfall=0, overrun=0.
- Overrun: give in any state other than IDLE is ignored and sets overrun; only clear or reset clears it.
- Other input rules:
  - eject_ack with no request pending is ignored.
  - give and clear in the same cycle in FAULT: clear wins, give is dropped.
  - Odd change (e.g. 7) pays 5 Rs coins down to a residual <5, then FAULT with shortfall=residual.
- Stock counters never underflow; DECIDE checks stock before ejecting.

Optional Feature:
- Macro: DISPENSE_COUNT_EN.
- Defined: adds output paid_total [9:0].
  - Reset 0; += 10 or 5 on each acknowledged coin eject; saturates at 1023; unaffected by refill and clear.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- reset, give product=11 change=15, ack each request 2 cycles after assertion -> product_release/product_sel=11, then coin10_eject, then coin5_eject, done pulse; stocks 7/7, busy low after done.
- give product=00 change=20 -> no product_release; two coin10_eject handshakes; coin10_stock=6 from 8; done=1 once.
- COIN10_INIT=1, give product=01 change=25 -> release, one coin10, three coin5; coin10_stock=0, coin5_stock=5; no error.
- give product=10 change=7 -> release, one coin5, then error=1, shortfall=2; clear -> error=0, IDLE; next give accepted.
- give product=11 change=10, never ack -> after 15 cycles in RELEASE, error=1, shortfall=10, product_release=0.
- give during EJ10 -> overrun=1, transaction unaffected; reset asserted in EJ5 -> next cycle all requests 0, stocks back to 8/8; with DISPENSE_COUNT_EN, paid_total=15 after the first scenario.
